gain_control_fsm: RTL and testbench



---
 rtl/gain_control_fsm.sv | 185 ++++++++++++++++++
 tb/tb_gain_control_fsm.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gain_control_fsm.sv
// gain_control_fsm: block-averaging AGC loop that steps amplifier gain
// toward TARGET_DB with a dead band, step limit and settle blanking.
// Ports: clk, rst_n (async low); enable_i freezes the loop when low;
// adc_dB_i/valid_i are the Q8.8 power stream; gain_o is the amplifier
// gain in dB, gain_update_o pulses on change, locked_o and saturated_o
// report the outcome of the last decision.
module gain_control_fsm #(
   parameter int unsigned TARGET_DB     = 60,
   parameter int unsigned HYST_DB       = 3,
   parameter int unsigned GAIN_MIN      = 0,
   parameter int unsigned GAIN_MAX      = 60,
   parameter int unsigned GAIN_INIT     = 30,
   parameter int unsigned STEP_MAX      = 12,
   parameter int unsigned AVG_LOG2      = 2,
   parameter int unsigned SETTLE_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable_i,
   input  logic [15:0] adc_dB_i,
   input  logic        valid_i,
   output logic [7:0]  gain_o,
   output logic        gain_update_o,
   output logic        locked_o,
   output logic        saturated_o
);

   localparam int ACC_W = 16 + AVG_LOG2;
   localparam int NS_W  = AVG_LOG2 + 1;
   localparam int CW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic signed [17:0] SMAX   = 18'(STEP_MAX);
   localparam logic signed [9:0]  GMIN_S = 10'(GAIN_MIN);
   localparam logic signed [9:0]  GMAX_S = 10'(GAIN_MAX);

   typedef enum logic [1:0] {
      HOLD   = 2'd0,
      SETTLE = 2'd1,
      ACCUM  = 2'd2,
      DECIDE = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [NS_W-1:0]    nsmp_q, nsmp_d;
   logic [7:0]         gain_q, gain_d;
   logic               upd_q, upd_d;
   logic               lock_q, lock_d;
   logic               sat_q, sat_d;

   // decision datapath, all Q8.8 until the step is rounded to whole dB
   logic [15:0]        mean;
   logic signed [17:0] err;
   logic [17:0]        abs_err;
   logic               in_band;
   logic signed [17:0] rnd;
   logic signed [17:0] stp;
   logic signed [17:0] stp_c;
   logic signed [9:0]  stp10;
   logic signed [9:0]  cand;
   logic [7:0]         new_g;
   logic               clamped;

   always_comb begin
      mean    = acc_q[ACC_W-1:AVG_LOG2];
      err     = $signed(18'(TARGET_DB * 256)) - $signed({2'b00, mean});
      abs_err = err[17] ? (~err + 18'd1) : err;
      in_band = abs_err <= 18'(HYST_DB * 256);
      rnd     = err + 18'sd128;
      stp     = rnd >>> 8;
      if (stp > SMAX) begin
         stp_c = SMAX;
      end else if (stp < -SMAX) begin
         stp_c = -SMAX;
      end else begin
         stp_c = stp;
      end
      stp10 = stp_c[9:0];
      cand  = $signed({2'b00, gain_q}) + stp10;
      if (cand < GMIN_S) begin
         new_g = 8'(GAIN_MIN);
      end else if (cand > GMAX_S) begin
         new_g = 8'(GAIN_MAX);
      end else begin
         new_g = cand[7:0];
      end
      clamped = $signed({2'b00, new_g}) != cand;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      nsmp_d  = nsmp_q;
      gain_d  = gain_q;
      upd_d   = 1'b0;
      lock_d  = lock_q;
      sat_d   = sat_q;
      unique case (state_q)
         HOLD: begin
            acc_d  = '0;
            nsmp_d = '0;
            lock_d = 1'b0;
            if (enable_i) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end
         end
         SETTLE: begin
            if (!enable_i) begin
               state_d = HOLD;
            end else if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
               state_d = ACCUM;
               acc_d   = '0;
               nsmp_d  = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ACCUM: begin
            if (!enable_i) begin
               state_d = HOLD;
            end else if (valid_i) begin
               acc_d  = acc_q + ACC_W'($signed(adc_dB_i));
               nsmp_d = nsmp_q + 1'b1;
               if (nsmp_q == NS_W'((1 << AVG_LOG2) - 1)) begin
                  state_d = DECIDE;
               end
            end
         end
         DECIDE: begin
            acc_d   = '0;
            nsmp_d  = '0;
            state_d = ACCUM;
            if (in_band) begin
               lock_d = 1'b1;
               sat_d  = 1'b0;
            end else begin
               lock_d = 1'b0;
               sat_d  = clamped;
               if (new_g != gain_q) begin
                  gain_d  = new_g;
                  upd_d   = 1'b1;
                  state_d = SETTLE;
                  cnt_d   = '0;
               end
            end
            // the decision above still commits; only the next state yields
            if (!enable_i) begin
               state_d = HOLD;
            end
         end
         default: state_d = HOLD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SETTLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         nsmp_q  <= '0;
         gain_q  <= 8'(GAIN_INIT);
         upd_q   <= 1'b0;
         lock_q  <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         nsmp_q  <= nsmp_d;
         gain_q  <= gain_d;
         upd_q   <= upd_d;
         lock_q  <= lock_d;
         sat_q   <= sat_d;
      end
   end

   assign gain_o        = gain_q;
   assign gain_update_o = upd_q;
   assign locked_o      = lock_q;
   assign saturated_o   = sat_q;

endmodule

// File: tb/tb_gain_control_fsm.sv
// tb_gain_control_fsm: drives gain_control_fsm with directed and random
// power streams and compares against a transaction-level loop model.
module tb_gain_control_fsm;

   localparam int TGT    = 60;
   localparam int HYST   = 3;
   localparam int GMIN   = 0;
   localparam int GMAX   = 60;
   localparam int GINIT  = 30;
   localparam int SMAX   = 12;
   localparam int NAVG   = 4;
   localparam int SETTLE = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable_i = 1'b0;
   logic        valid_i = 1'b0;
   logic [15:0] adc_dB_i = '0;
   logic [7:0]  gain_o;
   logic        gain_update_o;
   logic        locked_o;
   logic        saturated_o;

   int n_chk = 0;
   int n_fail = 0;

   gain_control_fsm dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable_i      (enable_i),
      .adc_dB_i      (adc_dB_i),
      .valid_i       (valid_i),
      .gain_o        (gain_o),
      .gain_update_o (gain_update_o),
      .locked_o      (locked_o),
      .saturated_o   (saturated_o)
   );

   always #5 clk = ~clk;

   // loop model: a timeline of when samples are accepted plus a
   // block-mean decision rule in plain integer arithmetic
   int m_cyc, m_open, m_gain;
   bit m_upd, m_lock, m_sat, m_pend, m_chg;
   int m_q[$];

   function automatic void m_reset();
      m_cyc  = 0;
      m_open = SETTLE + 1;
      m_gain = GINIT;
      m_upd  = 0;
      m_lock = 0;
      m_sat  = 0;
      m_pend = 0;
      m_chg  = 0;
      m_q.delete();
   endfunction

   function automatic int floor_div256(int x);
      if (x >= 0) return x / 256;
      return -((-x + 255) / 256);
   endfunction

   function automatic void m_decide();
      int sum, mean, err, stp, cand, nw;
      sum = 0;
      foreach (m_q[i]) sum += m_q[i];
      m_q.delete();
      mean = sum / NAVG;
      err  = TGT * 256 - mean;
      m_chg = 0;
      if (err <= HYST * 256 && err >= -HYST * 256) begin
         m_lock = 1;
         m_sat  = 0;
         return;
      end
      stp = floor_div256(err + 128);
      if (stp > SMAX) stp = SMAX;
      if (stp < -SMAX) stp = -SMAX;
      cand = m_gain + stp;
      nw = cand;
      if (nw < GMIN) nw = GMIN;
      if (nw > GMAX) nw = GMAX;
      m_sat  = (cand != nw);
      m_lock = 0;
      m_chg  = (nw != m_gain);
      m_gain = nw;
   endfunction

   function automatic void m_edge(bit v, logic [15:0] d);
      m_cyc++;
      m_upd = 0;
      if (m_pend) begin
         m_pend = 0;
         m_decide();
         m_upd  = m_chg;
         m_open = m_cyc + 1 + (m_chg ? SETTLE : 0);
      end else if (v && m_cyc >= m_open) begin
         m_q.push_back(int'(d));
         if (m_q.size() == NAVG) m_pend = 1;
      end
   endfunction

   task automatic cyc(input bit v, input logic [15:0] d);
      valid_i  = v;
      adc_dB_i = d;
      @(posedge clk);
      m_edge(v, d);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      enable_i = 1'b1;
      valid_i  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_reset();
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (gain_o !== 8'(GINIT)) begin
         n_fail++;
         $display("FAIL reset_gain: got %0d want %0d", gain_o, GINIT);
      end
      n_chk++;
      if (gain_update_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_upd: got %b want 0", gain_update_o);
      end
      n_chk++;
      if (locked_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_lock: got %b want 0", locked_o);
      end
      n_chk++;
      if (saturated_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_sat: got %b want 0", saturated_o);
      end
   endtask

   task automatic test_lock();
      do_reset();
      for (int i = 0; i < 80; i++) begin
         cyc(1'b1, 16'(60 * 256));
         n_chk++;
         if (gain_o !== 8'(m_gain) || gain_update_o !== m_upd ||
             locked_o !== m_lock || saturated_o !== m_sat) begin
            n_fail++;
            $display("FAIL lock_c%0d: got g=%0d u=%b l=%b s=%b want g=%0d u=%b l=%b s=%b",
                     m_cyc, gain_o, gain_update_o, locked_o, saturated_o,
                     m_gain, m_upd, m_lock, m_sat);
         end
         if (m_cyc == 68 || m_cyc == 69) begin
            n_chk++;
            if (locked_o !== (m_cyc == 69)) begin
               n_fail++;
               $display("FAIL lock_time c%0d: got %b want %b",
                        m_cyc, locked_o, m_cyc == 69);
            end
         end
      end
   endtask

   task automatic test_step_up();
      int pulses = 0;
      int first = 0;
      do_reset();
      for (int i = 0; i < 180; i++) begin
         cyc(1'b1, 16'(40 * 256));
         if (gain_update_o === 1'b1) begin
            pulses++;
            if (first == 0) first = m_cyc;
         end
         n_chk++;
         if (gain_o !== 8'(m_gain) || gain_update_o !== m_upd ||
             saturated_o !== m_sat) begin
            n_fail++;
            $display("FAIL step_c%0d: got g=%0d u=%b s=%b want g=%0d u=%b s=%b",
                     m_cyc, gain_o, gain_update_o, saturated_o,
                     m_gain, m_upd, m_sat);
         end
      end
      n_chk++;
      if (first != 69) begin
         n_fail++;
         $display("FAIL step_first_pulse: got c%0d want c69", first);
      end
      n_chk++;
      if (gain_o !== 8'd54 || saturated_o !== 1'b0 || pulses != 2) begin
         n_fail++;
         $display("FAIL step_final: got g=%0d s=%b p=%0d want g=54 s=0 p=2",
                  gain_o, saturated_o, pulses);
      end
   endtask

   task automatic test_rail();
      int pulses = 0;
      do_reset();
      for (int i = 0; i < 380; i++) begin
         cyc(1'b1, 16'(72 * 256));
         if (gain_update_o === 1'b1) pulses++;
         n_chk++;
         if (gain_o !== 8'(m_gain) || gain_update_o !== m_upd ||
             locked_o !== m_lock || saturated_o !== m_sat) begin
            n_fail++;
            $display("FAIL rail_c%0d: got g=%0d u=%b l=%b s=%b want g=%0d u=%b l=%b s=%b",
                     m_cyc, gain_o, gain_update_o, locked_o, saturated_o,
                     m_gain, m_upd, m_lock, m_sat);
         end
      end
      n_chk++;
      if (gain_o !== 8'd0 || saturated_o !== 1'b1 || pulses != 3) begin
         n_fail++;
         $display("FAIL rail_final: got g=%0d s=%b p=%0d want g=0 s=1 p=3",
                  gain_o, saturated_o, pulses);
      end
   endtask

   task automatic test_hyst();
      logic [15:0] d;
      do_reset();
      for (int i = 0; i < 79; i++) begin
         if (i < 69) d = (i % 2 == 0) ? 16'(62 * 256) : 16'(59 * 256);
         else d = 16'(64 * 256);
         cyc(1'b1, d);
         n_chk++;
         if (gain_o !== 8'(m_gain) || gain_update_o !== m_upd ||
             locked_o !== m_lock || saturated_o !== m_sat) begin
            n_fail++;
            $display("FAIL hyst_c%0d: got g=%0d u=%b l=%b s=%b want g=%0d u=%b l=%b s=%b",
                     m_cyc, gain_o, gain_update_o, locked_o, saturated_o,
                     m_gain, m_upd, m_lock, m_sat);
         end
         if (m_cyc == 70) begin
            n_chk++;
            if (locked_o !== 1'b1 || gain_o !== 8'd30) begin
               n_fail++;
               $display("FAIL hyst_band: got l=%b g=%0d want l=1 g=30",
                        locked_o, gain_o);
            end
         end
      end
      n_chk++;
      if (gain_o !== 8'd26 || locked_o !== 1'b0) begin
         n_fail++;
         $display("FAIL hyst_step: got g=%0d l=%b want g=26 l=0",
                  gain_o, locked_o);
      end
   endtask

   task automatic test_random();
      bit v;
      logic [15:0] d;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         v = ($urandom_range(0, 3) != 0);
         if (m_pend || m_cyc + 1 < m_open) d = 16'd0;
         else d = 16'($urandom_range(45 * 256, 75 * 256));
         cyc(v, d);
         n_chk++;
         if (gain_o !== 8'(m_gain) || gain_update_o !== m_upd ||
             locked_o !== m_lock || saturated_o !== m_sat) begin
            n_fail++;
            $display("FAIL rand_c%0d: got g=%0d u=%b l=%b s=%b want g=%0d u=%b l=%b s=%b",
                     m_cyc, gain_o, gain_update_o, locked_o, saturated_o,
                     m_gain, m_upd, m_lock, m_sat);
         end
      end
   endtask

   task automatic test_enable();
      int k = 0;
      bit seen = 0;
      int early = 0;
      do_reset();
      for (int i = 1; i <= 71; i++) begin
         cyc(1'b1, (i <= 69) ? 16'(60 * 256) : 16'(72 * 256));
      end
      enable_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 16'd0);
         if (gain_update_o === 1'b1) early++;
      end
      n_chk++;
      if (locked_o !== 1'b0 || gain_o !== 8'd30 || early != 0) begin
         n_fail++;
         $display("FAIL hold_state: got l=%b g=%0d p=%0d want l=0 g=30 p=0",
                  locked_o, gain_o, early);
      end
      enable_i = 1'b1;
      for (int i = 0; i < 200 && !seen; i++) begin
         cyc(1'b1, 16'(40 * 256));
         if (gain_update_o === 1'b1) begin
            seen = 1;
            k = i;
         end
      end
      n_chk++;
      if (!seen || k != 69) begin
         n_fail++;
         $display("FAIL resume_timing: got seen=%b k=%0d want seen=1 k=69",
                  seen, k);
      end
      n_chk++;
      if (gain_o !== 8'd42) begin
         n_fail++;
         $display("FAIL resume_gain: got %0d want 42", gain_o);
      end
      for (int i = 0; i < 5; i++) cyc(1'b1, 16'(40 * 256));
      rst_n = 1'b0;
      #2;
      n_chk++;
      if (gain_o !== 8'(GINIT) || gain_update_o !== 1'b0 ||
          locked_o !== 1'b0 || saturated_o !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: got g=%0d u=%b l=%b s=%b want g=30 u=0 l=0 s=0",
                  gain_o, gain_update_o, locked_o, saturated_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_lock();
      test_step_up();
      test_rail();
      test_hyst();
      test_random();
      test_enable();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
